// File: rtl/seq_ser_pkg.sv
// Shared definitions for the parallel-to-serial FSM input stage:
// state typedef and its encodings.
package seq_ser_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        GAP   = ST_GAP
    } seq_ser_state_t;

endpackage

// File: rtl/seq_serializer_nb.sv
// Serializes an NBITS word received over val/rdy into a one-bit-per-cycle
// stream, followed by GAP_CYCLES idle-zero cycles between words.
module seq_serializer_nb
    import seq_ser_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int LSB_FIRST  = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_msg,
    output logic             out_,
    output logic             out_val,
    output logic             last
);

    localparam int IW = $clog2(NBITS);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(NBITS - 1);
    localparam logic [GW-1:0] GCNT_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_ser_state_t   r_state, w_state_nxt;
    logic [NBITS-1:0] r_sreg,  w_sreg_nxt;
    logic [IW-1:0]    r_idx,   w_idx_nxt;
    logic [GW-1:0]    r_gcnt,  w_gcnt_nxt;

    logic w_at_last;
    logic w_xfer;

    assign w_at_last = (r_state == SHIFT) && (r_idx == IDX_LAST);
    assign w_xfer    = in_val && in_rdy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_idx   <= '0;
            r_gcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_idx   <= w_idx_nxt;
            r_gcnt  <= w_gcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_idx_nxt   = r_idx;
        w_gcnt_nxt  = r_gcnt;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = SHIFT;
                    w_sreg_nxt  = in_msg;
                    w_idx_nxt   = '0;
                end
            end
            SHIFT: begin
                w_sreg_nxt = (LSB_FIRST != 0) ? {1'b0, r_sreg[NBITS-1:1]}
                                              : {r_sreg[NBITS-2:0], 1'b0};
                w_idx_nxt  = r_idx + 1'b1;
                if (w_at_last) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = GAP;
                        w_gcnt_nxt  = '0;
                    end else if (w_xfer) begin
                        // Zero-gap mode: next word loads on the final bit, no bubble.
                        w_sreg_nxt = in_msg;
                        w_idx_nxt  = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                w_gcnt_nxt = r_gcnt + 1'b1;
                if (r_gcnt == GCNT_LAST) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decode registered state only; in_rdy is additionally held low in reset.
    always_comb begin
        out_    = 1'b0;
        out_val = 1'b0;
        last    = 1'b0;
        in_rdy  = 1'b0;
        case (r_state)
            IDLE: in_rdy = reset_n;
            SHIFT: begin
                out_val = 1'b1;
                out_    = (LSB_FIRST != 0) ? r_sreg[0] : r_sreg[NBITS-1];
                last    = w_at_last;
                in_rdy  = reset_n && w_at_last && (GAP_CYCLES == 0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_serializer_nb.sv
// Directed bench: three configurations (LSB/gap1, MSB/gap1, LSB/gap0)
// checked cycle by cycle against hand-computed streams.
module tb_seq_serializer_nb;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       a_val, a_rdy, a_out, a_oval, a_last;
    logic [7:0] a_msg;
    logic       b_val, b_rdy, b_out, b_oval, b_last;
    logic [7:0] b_msg;
    logic       c_val, c_rdy, c_out, c_oval, c_last;
    logic [7:0] c_msg;

    int tests = 0;
    int fails = 0;

    seq_serializer_nb #(.NBITS(8), .LSB_FIRST(1), .GAP_CYCLES(1)) u_a (
        .clk(clk), .reset_n(reset_n), .in_val(a_val), .in_rdy(a_rdy),
        .in_msg(a_msg), .out_(a_out), .out_val(a_oval), .last(a_last));

    seq_serializer_nb #(.NBITS(8), .LSB_FIRST(0), .GAP_CYCLES(1)) u_b (
        .clk(clk), .reset_n(reset_n), .in_val(b_val), .in_rdy(b_rdy),
        .in_msg(b_msg), .out_(b_out), .out_val(b_oval), .last(b_last));

    seq_serializer_nb #(.NBITS(8), .LSB_FIRST(1), .GAP_CYCLES(0)) u_c (
        .clk(clk), .reset_n(reset_n), .in_val(c_val), .in_rdy(c_rdy),
        .in_msg(c_msg), .out_(c_out), .out_val(c_oval), .last(c_last));

    // Checks compare {out_, out_val, last, in_rdy} sampled on the falling edge.
    task automatic test_reset();
        logic [3:0] exp;
        reset_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({a_rdy, b_rdy, c_rdy} !== 3'b000) begin
            fails++;
            $display("FAIL reset_rdy got=%b exp=000", {a_rdy, b_rdy, c_rdy});
        end
        @(negedge clk);
        exp = 4'b0000;
        tests++;
        if ({a_out, a_oval, a_last, a_rdy} !== exp) begin
            fails++;
            $display("FAIL reset_hold got=%b exp=%b", {a_out, a_oval, a_last, a_rdy}, exp);
        end
        reset_n = 1'b1;
        #1;
        exp = 4'b0001;
        tests++;
        if ({a_out, a_oval, a_last, a_rdy} !== exp ||
            {b_out, b_oval, b_last, b_rdy} !== exp ||
            {c_out, c_oval, c_last, c_rdy} !== exp) begin
            fails++;
            $display("FAIL reset_release a=%b b=%b c=%b exp=%b", {a_out, a_oval, a_last, a_rdy},
                     {b_out, b_oval, b_last, b_rdy}, {c_out, c_oval, c_last, c_rdy}, exp);
        end
        @(negedge clk);
        tests++;
        if ({a_out, a_oval, a_last, a_rdy} !== exp) begin
            fails++;
            $display("FAIL idle_after_reset got=%b exp=%b", {a_out, a_oval, a_last, a_rdy}, exp);
        end
    endtask

    task automatic test_single();
        logic [7:0] bits;
        logic [3:0] exp;
        bits = 8'b0110_1101; // 6D bit-reversed stream order: 1,0,1,1,0,1,1,0
        a_msg = 8'h6D; a_val = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin a_val = 1'b0; a_msg = 8'h00; end
            exp = {bits[i], 1'b1, (i == 7), 1'b0};
            tests++;
            if ({a_out, a_oval, a_last, a_rdy} !== exp) begin
                fails++;
                $display("FAIL single_bit%0d got=%b exp=%b", i, {a_out, a_oval, a_last, a_rdy}, exp);
            end
        end
        @(negedge clk);
        tests++;
        if ({a_out, a_oval, a_last, a_rdy} !== 4'b0000) begin
            fails++;
            $display("FAIL single_gap got=%b exp=0000", {a_out, a_oval, a_last, a_rdy});
        end
        @(negedge clk);
        tests++;
        if ({a_out, a_oval, a_last, a_rdy} !== 4'b0001) begin
            fails++;
            $display("FAIL single_idle got=%b exp=0001", {a_out, a_oval, a_last, a_rdy});
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] seq;
        logic [3:0] exp;
        seq = 8'b1011_0110; // seq[i] is the i-th bit out: 0,1,1,0,1,1,0,1
        b_msg = 8'h6D; b_val = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin b_val = 1'b0; b_msg = 8'h00; end
            exp = {seq[i], 1'b1, (i == 7), 1'b0};
            tests++;
            if ({b_out, b_oval, b_last, b_rdy} !== exp) begin
                fails++;
                $display("FAIL msb_bit%0d got=%b exp=%b", i, {b_out, b_oval, b_last, b_rdy}, exp);
            end
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({b_out, b_oval, b_last, b_rdy} !== 4'b0001) begin
            fails++;
            $display("FAIL msb_idle got=%b exp=0001", {b_out, b_oval, b_last, b_rdy});
        end
    endtask

    task automatic test_back_to_back();
        logic       lst;
        logic [3:0] exp;
        c_msg = 8'hFF; c_val = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) c_msg = 8'h00;
            if (i == 8) c_val = 1'b0;
            lst = (i == 7) || (i == 15);
            exp = {(i < 8), 1'b1, lst, lst};
            tests++;
            if ({c_out, c_oval, c_last, c_rdy} !== exp) begin
                fails++;
                $display("FAIL b2b_cyc%0d got=%b exp=%b", i, {c_out, c_oval, c_last, c_rdy}, exp);
            end
        end
        @(negedge clk);
        tests++;
        if ({c_out, c_oval, c_last, c_rdy} !== 4'b0001) begin
            fails++;
            $display("FAIL b2b_idle got=%b exp=0001", {c_out, c_oval, c_last, c_rdy});
        end
    endtask

    task automatic test_ignored_input();
        logic [7:0] w0, w1;
        logic [3:0] exp;
        w0 = 8'h0F;
        w1 = 8'hAA;
        a_msg = w0; a_val = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) a_val = 1'b0;
            if (i == 2) begin a_val = 1'b1; a_msg = 8'hAA; end
            exp = {w0[i], 1'b1, (i == 7), 1'b0};
            tests++;
            if ({a_out, a_oval, a_last, a_rdy} !== exp) begin
                fails++;
                $display("FAIL ignored_w0_bit%0d got=%b exp=%b", i, {a_out, a_oval, a_last, a_rdy}, exp);
            end
        end
        @(negedge clk);
        tests++;
        if ({a_out, a_oval, a_last, a_rdy} !== 4'b0000) begin
            fails++;
            $display("FAIL ignored_gap got=%b exp=0000", {a_out, a_oval, a_last, a_rdy});
        end
        @(negedge clk);
        tests++;
        if (a_rdy !== 1'b1) begin
            fails++;
            $display("FAIL ignored_rdy got=%b exp=1", a_rdy);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin a_val = 1'b0; a_msg = 8'h00; end
            exp = {w1[i], 1'b1, (i == 7), 1'b0};
            tests++;
            if ({a_out, a_oval, a_last, a_rdy} !== exp) begin
                fails++;
                $display("FAIL ignored_w1_bit%0d got=%b exp=%b", i, {a_out, a_oval, a_last, a_rdy}, exp);
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [7:0] w0, w1;
        logic [3:0] exp;
        w0 = 8'h6D;
        w1 = 8'h01;
        a_msg = w0; a_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) a_val = 1'b0;
            exp = {w0[i], 1'b1, 1'b0, 1'b0};
            tests++;
            if ({a_out, a_oval, a_last, a_rdy} !== exp) begin
                fails++;
                $display("FAIL midrst_bit%0d got=%b exp=%b", i, {a_out, a_oval, a_last, a_rdy}, exp);
            end
        end
        reset_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({a_out, a_oval, a_last, a_rdy} !== 4'b0000) begin
            fails++;
            $display("FAIL midrst_flush got=%b exp=0000", {a_out, a_oval, a_last, a_rdy});
        end
        reset_n = 1'b1;
        a_msg = w1; a_val = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) a_val = 1'b0;
            exp = {w1[i], 1'b1, (i == 7), 1'b0};
            tests++;
            if ({a_out, a_oval, a_last, a_rdy} !== exp) begin
                fails++;
                $display("FAIL midrst_new_bit%0d got=%b exp=%b", i, {a_out, a_oval, a_last, a_rdy}, exp);
            end
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({a_out, a_oval, a_last, a_rdy} !== 4'b0001) begin
            fails++;
            $display("FAIL midrst_idle got=%b exp=0001", {a_out, a_oval, a_last, a_rdy});
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_val = 1'b0; a_msg = '0;
        b_val = 1'b0; b_msg = '0;
        c_val = 1'b0; c_msg = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_msb_first();
        test_back_to_back();
        test_ignored_input();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
